// File: rtl/nfca_crc_framer.sv
// nfca_crc_framer: CRC_A append on TX, CRC_A check/strip on RX,
// between user byte streams and the NFC-A controller.
module nfca_crc_framer #(
   parameter logic [15:0] CRC_INIT = 16'h6363
) (
   input  logic       rstn,
   input  logic       clk,
   input  logic       u_tx_tvalid,
   output logic       u_tx_tready,
   input  logic [7:0] u_tx_tdata,
   input  logic [3:0] u_tx_tdatab,
   input  logic       u_tx_tlast,
   input  logic       u_tx_tcrc,
   output logic       tx_tvalid,
   input  logic       tx_tready,
   output logic [7:0] tx_tdata,
   output logic [3:0] tx_tdatab,
   output logic       tx_tlast,
   input  logic       rx_crc_en,
   input  logic       rx_tvalid,
   input  logic [7:0] rx_tdata,
   input  logic [3:0] rx_tdatab,
   input  logic       rx_tend,
   input  logic       rx_terr,
   output logic       u_rx_tvalid,
   output logic [7:0] u_rx_tdata,
   output logic [3:0] u_rx_tdatab,
   output logic       u_rx_tend,
   output logic       u_rx_terr,
   output logic       u_rx_tcrcok
);

   typedef enum logic [1:0] {T_DATA, T_CRC0, T_CRC1} tx_st_t;
   typedef enum logic [1:0] {R_IDLE, R_FRAME, R_FLUSH} rx_st_t;

   function automatic logic [15:0] f_crc(input logic [15:0] c_in,
                                         input logic [7:0]  b);
      logic [15:0] c;
      c = c_in;
      for (int i = 0; i < 8; i++)
         c = (c[0] ^ b[i]) ? ((c >> 1) ^ 16'h8408) : (c >> 1);
      return c;
   endfunction

   tx_st_t      r_tx_st, w_tx_st_n;
   logic [15:0] r_tx_crc, w_tx_crc_n;
   logic        r_tx_first, w_tx_first_n;
   logic        r_tx_app, w_tx_app_n;
   logic        w_app, w_hs;

   // TX: pass-through in T_DATA, then two CRC bytes when appending
   always_comb begin
      w_app        = r_tx_first ? u_tx_tcrc : r_tx_app;
      w_hs         = 1'b0;
      w_tx_st_n    = r_tx_st;
      w_tx_crc_n   = r_tx_crc;
      w_tx_first_n = r_tx_first;
      w_tx_app_n   = r_tx_app;
      tx_tvalid    = u_tx_tvalid;
      u_tx_tready  = tx_tready;
      tx_tdata     = u_tx_tdata;
      tx_tdatab    = u_tx_tdatab;
      tx_tlast     = u_tx_tlast & ~(w_app & (u_tx_tdatab == 4'd8));
      unique case (r_tx_st)
         T_DATA: begin
            w_hs = u_tx_tvalid & tx_tready;
            if (w_hs) begin
               w_tx_first_n = u_tx_tlast;
               w_tx_app_n   = w_app;
               if (w_app)
                  w_tx_crc_n = f_crc(r_tx_crc, u_tx_tdata);
               if (u_tx_tlast) begin
                  if (w_app && u_tx_tdatab == 4'd8)
                     w_tx_st_n = T_CRC0;
                  else
                     w_tx_crc_n = CRC_INIT;
               end
            end
         end
         T_CRC0: begin
            tx_tvalid   = 1'b1;
            tx_tdata    = r_tx_crc[7:0];
            tx_tdatab   = 4'd8;
            tx_tlast    = 1'b0;
            u_tx_tready = 1'b0;
            if (tx_tready)
               w_tx_st_n = T_CRC1;
         end
         T_CRC1: begin
            tx_tvalid   = 1'b1;
            tx_tdata    = r_tx_crc[15:8];
            tx_tdatab   = 4'd8;
            tx_tlast    = 1'b1;
            u_tx_tready = 1'b0;
            if (tx_tready) begin
               w_tx_st_n  = T_DATA;
               w_tx_crc_n = CRC_INIT;
            end
         end
         default: ;
      endcase
   end

   // TX state register
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_tx_st    <= T_DATA;
         r_tx_crc   <= CRC_INIT;
         r_tx_first <= 1'b1;
         r_tx_app   <= 1'b0;
      end else begin
         r_tx_st    <= w_tx_st_n;
         r_tx_crc   <= w_tx_crc_n;
         r_tx_first <= w_tx_first_n;
         r_tx_app   <= w_tx_app_n;
      end
   end

   rx_st_t      r_rx_st, w_rx_st_n;
   logic [15:0] r_rx_crc, w_rx_crc_n;
   logic [11:0] r_buf0, r_buf1, w_buf0_n, w_buf1_n, w_rx_in;
   logic [1:0]  r_cnt, w_cnt_n;
   logic [2:0]  r_tot, w_tot_n;
   logic        r_part, w_part_n;
   logic        r_en, w_en_n, w_en_now;
   logic        r_ok, w_ok_n;
   logic        r_err, w_err_n;
   logic        w_clr, w_ovalid, w_oend;
   logic [11:0] w_odata;
   logic        r_o_valid, r_o_end, r_o_ok, r_o_err;
   logic [11:0] r_o_data;

   // RX: two-byte delay line holds back the CRC, flush on failure
   always_comb begin
      w_rx_st_n  = r_rx_st;
      w_rx_crc_n = r_rx_crc;
      w_buf0_n   = r_buf0;
      w_buf1_n   = r_buf1;
      w_cnt_n    = r_cnt;
      w_tot_n    = r_tot;
      w_part_n   = r_part;
      w_en_n     = r_en;
      w_ok_n     = r_ok;
      w_err_n    = r_err;
      w_clr      = 1'b0;
      w_ovalid   = 1'b0;
      w_oend     = 1'b0;
      w_odata    = r_o_data;
      w_rx_in    = {rx_tdatab, rx_tdata};
      w_en_now   = (r_rx_st == R_IDLE) ? rx_crc_en : r_en;
      unique case (r_rx_st)
         R_IDLE, R_FRAME: begin
            if (rx_tvalid | rx_tend) begin
               w_rx_st_n = R_FRAME;
               w_en_n    = w_en_now;
            end
            if (rx_tvalid) begin
               w_rx_crc_n = f_crc(r_rx_crc, rx_tdata);
               w_tot_n    = (r_tot == 3'd7) ? 3'd7 : r_tot + 3'd1;
               w_part_n   = r_part | (rx_tdatab != 4'd8);
               if (!w_en_now) begin
                  w_ovalid = 1'b1;
                  w_odata  = w_rx_in;
               end else if (r_cnt == 2'd2) begin
                  w_ovalid = 1'b1;
                  w_odata  = r_buf0;
                  w_buf0_n = r_buf1;
                  w_buf1_n = w_rx_in;
               end else if (r_cnt == 2'd1) begin
                  w_buf1_n = w_rx_in;
                  w_cnt_n  = 2'd2;
               end else begin
                  w_buf0_n = w_rx_in;
                  w_cnt_n  = 2'd1;
               end
            end
            if (rx_tend) begin
               w_ok_n  = w_en_now & ~rx_terr & ~w_part_n &
                         (w_tot_n >= 3'd3) & (w_rx_crc_n == 16'h0);
               w_err_n = rx_terr;
               if (w_ok_n)
                  w_cnt_n = 2'd0;
               if (w_cnt_n == 2'd0 && !w_ovalid) begin
                  w_oend    = 1'b1;
                  w_rx_st_n = R_IDLE;
                  w_clr     = 1'b1;
               end else begin
                  w_rx_st_n = R_FLUSH;
               end
            end
         end
         R_FLUSH: begin
            if (r_cnt != 2'd0) begin
               w_ovalid = 1'b1;
               w_odata  = r_buf0;
               w_buf0_n = r_buf1;
               w_cnt_n  = r_cnt - 2'd1;
            end else begin
               w_oend    = 1'b1;
               w_rx_st_n = R_IDLE;
               w_clr     = 1'b1;
            end
         end
         default: ;
      endcase
      if (w_clr) begin
         w_rx_crc_n = CRC_INIT;
         w_tot_n    = 3'd0;
         w_part_n   = 1'b0;
         w_cnt_n    = 2'd0;
      end
   end

   // RX state and registered user-side outputs
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_rx_st   <= R_IDLE;
         r_rx_crc  <= CRC_INIT;
         r_buf0    <= 12'h0;
         r_buf1    <= 12'h0;
         r_cnt     <= 2'd0;
         r_tot     <= 3'd0;
         r_part    <= 1'b0;
         r_en      <= 1'b0;
         r_ok      <= 1'b0;
         r_err     <= 1'b0;
         r_o_valid <= 1'b0;
         r_o_data  <= 12'h0;
         r_o_end   <= 1'b0;
         r_o_ok    <= 1'b0;
         r_o_err   <= 1'b0;
      end else begin
         r_rx_st   <= w_rx_st_n;
         r_rx_crc  <= w_rx_crc_n;
         r_buf0    <= w_buf0_n;
         r_buf1    <= w_buf1_n;
         r_cnt     <= w_cnt_n;
         r_tot     <= w_tot_n;
         r_part    <= w_part_n;
         r_en      <= w_en_n;
         r_ok      <= w_ok_n;
         r_err     <= w_err_n;
         r_o_valid <= w_ovalid;
         r_o_data  <= w_odata;
         r_o_end   <= w_oend;
         r_o_ok    <= w_oend & w_ok_n;
         r_o_err   <= w_oend & w_err_n;
      end
   end

   assign u_rx_tvalid = r_o_valid;
   assign u_rx_tdata  = r_o_data[7:0];
   assign u_rx_tdatab = r_o_data[11:8];
   assign u_rx_tend   = r_o_end;
   assign u_rx_tcrcok = r_o_ok;
   assign u_rx_terr   = r_o_err;

endmodule
